// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier with start/finish handshake.
// Retires two multiplier bits per cycle; the result is held until the next accepted Start.
module booth_radix4_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 Resetn,
   input  logic                 Start,
   input  logic                 Signed,
   input  logic [WIDTH-1:0]     Mplier,
   input  logic [WIDTH-1:0]     Mcand,
   output logic                 Busy,
   output logic                 Finish,
   output logic [2*WIDTH-1:0]   FProduct
);

   localparam int E     = WIDTH + 2;
   localparam int STEPS = WIDTH / 2 + 1;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;

   logic [E-1:0]           r_M;
   logic [E-1:0]           r_Q;
   logic signed [E:0]      r_A;
   logic                   r_qm1;
   logic [CW-1:0]          r_count;
   logic [2*WIDTH-1:0]     r_product;

   logic [E-1:0]           w_mcandExt;
   logic [E-1:0]           w_mplierExt;
   logic signed [E:0]      w_mExt;
   logic signed [E:0]      w_multiple;
   logic signed [E:0]      w_sum;
   logic signed [E:0]      w_shiftA;
   logic [E-1:0]           w_shiftQ;
   logic                   w_lastStep;
   logic                   w_accept;

   // Operands are widened by two bits so the top Booth digit is always in range,
   // and unsigned values stay positive after sign-style recoding.
   always_comb begin
      w_mcandExt  = Signed ? {{2{Mcand[WIDTH-1]}}, Mcand}   : {2'b00, Mcand};
      w_mplierExt = Signed ? {{2{Mplier[WIDTH-1]}}, Mplier} : {2'b00, Mplier};
   end

   assign w_accept   = (r_state == IDLE) && Start;
   assign w_lastStep = (r_count == CW'(STEPS - 1));

   // Booth digit selection; negation happens in E+1 bits so the most negative M cannot overflow.
   always_comb begin
      w_mExt     = {r_M[E-1], r_M};
      w_multiple = '0;
      case ({r_Q[1:0], r_qm1})
         3'b001, 3'b010: w_multiple = w_mExt;
         3'b011:         w_multiple = w_mExt <<< 1;
         3'b100:         w_multiple = -(w_mExt <<< 1);
         3'b101, 3'b110: w_multiple = -w_mExt;
         default:        w_multiple = '0;
      endcase
   end

   always_comb begin
      w_sum    = r_A + w_multiple;
      w_shiftA = {w_sum[E], w_sum[E], w_sum[E:2]};
      w_shiftQ = {w_sum[1:0], r_Q[E-1:2]};
   end

   always_ff @(posedge clk or posedge Resetn) begin
      if (Resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Busy and Finish come straight from the state register, so they never glitch.
   always_comb begin
      w_nextState = r_state;
      Busy        = 1'b0;
      Finish      = 1'b0;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_nextState = CALC;
            end
         end
         CALC: begin
            Busy = 1'b1;
            if (w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            Finish      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The product register is written only on the final iteration, so it holds through IDLE.
   always_ff @(posedge clk or posedge Resetn) begin
      if (Resetn) begin
         r_M       <= '0;
         r_Q       <= '0;
         r_A       <= '0;
         r_qm1     <= 1'b0;
         r_count   <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_M       <= w_mcandExt;
         r_Q       <= w_mplierExt;
         r_A       <= '0;
         r_qm1     <= 1'b0;
         r_count   <= '0;
      end else if (r_state == CALC) begin
         r_A       <= w_shiftA;
         r_Q       <= w_shiftQ;
         r_qm1     <= r_Q[1];
         r_count   <= r_count + CW'(1);
         if (w_lastStep) begin
            r_product <= {w_shiftA[WIDTH-3:0], w_shiftQ};
         end
      end
   end

   assign FProduct = r_product;

endmodule

// File: doc/booth_radix4_mult.md
# booth_radix4_mult

Parametrised sequential radix-4 Booth multiplier, successor to the lab 8-bit radix-2 Booth unit. It multiplies two WIDTH-bit operands in either signed or unsigned mode. It retires two multiplier bits per cycle, so an 8-bit multiply takes 5 compute cycles instead of 8. It sits behind the lab datapath/controller as a start/finish-handshaked arithmetic unit, and its result is held stable until the next accepted Start.

## Interface
- WIDTH, 8: operand width; must be even and ≥4
- clk  input  1  clock; all state updates on the rising edge
- Resetn  input  1  reset; asynchronous, active-high
- Start  input  1  request; sampled only in IDLE
- Signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with Start
- Mplier  input  WIDTH  multiplier; latched with Start
- Mcand  input  WIDTH  multiplicand; latched with Start
- Busy  output  1  high while in CALC
- Finish  output  1  one-cycle pulse in DONE
- FProduct  output  2*WIDTH  result register; two's-complement in signed mode

## Operation
- Constants:
  - E = WIDTH+2, the extended operand width
  - STEPS = WIDTH/2+1, the number of radix-4 iterations
- States: IDLE, CALC, DONE.
- IDLE:
  - Start=1 latches the operands.
  - Both operands are sign-extended (Signed=1) or zero-extended (Signed=0) to E bits: M = Mcand, Q = Mplier.
  - Clears accumulator A (E+1 bits, signed), q-1 bit, and step counter; go to CALC.
  - Start=0: stay in IDLE.
- CALC, one iteration per cycle:
  - Recode {Q[1],Q[0],q-1}:
    - 000/111 → 0
    - 001/010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101/110 → −M
  - A' = A + multiple, computed in E+1 bits with M sign-extended. −M is formed as two's complement in E+1 bits, so there is no overflow for M = −2^(WIDTH−1).
  - {A,Q,q-1} ← arithmetic shift right by 2 of {A',Q,q-1}.
  - Counter increments each iteration.
  - After iteration STEPS: FProduct ← low 2*WIDTH bits of {A,Q}; go to DONE.
- DONE: Finish=1 for exactly one cycle; go to IDLE unconditionally.
- Start is ignored in CALC and DONE; there is no queueing.
- The operand inputs may change freely after the accept edge.
- FProduct changes only on the final CALC edge or on reset. It holds its value through IDLE, including across ignored Starts.
- Busy = (state==CALC); Finish = (state==DONE). Both are decoded from registered state, so they are glitch-free.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE
  - Busy 0, Finish 0, FProduct 0
  - internal registers 0
- Reset asserted mid-CALC or in DONE aborts the operation; no Finish pulse is produced for it.
- Reset has priority over every event, including a simultaneous Start.
- Latency: Start accepted at edge k.
  - Busy is high from edge k to edge k+STEPS.
  - FProduct is valid and Finish is high from edge k+STEPS to edge k+STEPS+1.
  - For WIDTH=8: Finish is high in the cycle after edge k+5.
- Earliest next accept is edge k+STEPS+2, because Start must be seen in IDLE. The throughput is one multiply per STEPS+2 cycles.
- Start held high continuously: a new operation is accepted on every IDLE cycle, giving back-to-back operations with the same period.

## Test plan
- WIDTH=8, Signed=1, Mplier=0x80, Mcand=0x80 → Finish pulse exactly 5 cycles after the accept edge, FProduct=0x4000; Busy high for 5 cycles.
- WIDTH=8, Signed=0, 0xFF×0xFF → 0xFE01. Same operands with Signed=1 → 0x0001.
- WIDTH=8, Signed=1, 0x7F×0x80 → 0xC080 (−16256). Signed=1, 0xC8×0x03 → 0xFF58 (−168). Signed=0, 0xC8×0x03 → 0x0258 (600).
- Pulse Start again during CALC with different operands → first result is unaffected and only one Finish pulse occurs. FProduct holds 0xFF58 through the following IDLE cycles.
- Assert Resetn on the 3rd CALC cycle → Busy=0, Finish=0, FProduct=0 immediately. Start 2 cycles after reset release with 0x05×0xFD signed → 0xFFF1.
- WIDTH=16: 1000 random operand pairs in each mode, checked against a reference model → all match; each Finish is exactly 9 cycles after its accept edge; back-to-back period is 11 cycles.
